// File: rtl/snd_pkg.sv
// Shared types and constants for the cartridge expansion-audio DAC output stage.
package snd_pkg;

    localparam int GAIN_UNITY = 16;
    localparam int GAIN_W     = 5;
    localparam int SND_W      = 16;

    typedef enum logic [1:0] {
        S_ZERO   = 2'd0,
        S_UP     = 2'd1,
        S_STEADY = 2'd2,
        S_DOWN   = 2'd3
    } snd_ramp_t;

endpackage

// File: rtl/snd_dac_out_sdm.sv
// First-order sigma-delta modulator: the carry out of a W-bit phase accumulator
// is the 1-bit output, so its ones-density equals din / 2^W.
module snd_sdm #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] r_acc;
    logic         r_dout;
    logic [W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, din};
    assign dout  = r_dout;

    // Accumulate every clock and register the carry as the output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_dout <= 1'b0;
        end else begin
            r_acc  <= w_sum[W-1:0];
            r_dout <= w_sum[W];
        end
    end

endmodule

// File: rtl/snd_dac_out.sv
// Mapper audio to 1-bit DAC pin: sample capture, pop-free gain ramp with mute,
// saturating scale, first-order IIR low-pass and sigma-delta conversion.
module snd_dac_out
    import snd_pkg::*;
#(
    parameter int W      = SND_W,
    parameter int LPF_SH = 4,
    parameter int DIV    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      snd_in,
    input  logic              snd_stb,
    input  logic [GAIN_W-1:0] vol,
    input  logic              mute,
    output logic              dac_out,
    output logic              muted,
    output logic              clip
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = W + LPF_SH;
    localparam int G_SH  = $clog2(GAIN_UNITY);

    // Saturate the one-bit-wider scaled value to full scale.
    function automatic logic [W-1:0] sat_u(input logic [W:0] v);
        return v[W] ? {W{1'b1}} : v[W-1:0];
    endfunction

    logic [W-1:0]        r_x;
    logic [CNT_W-1:0]    r_cnt;
    snd_ramp_t           r_state;
    snd_ramp_t           w_state_nxt;
    logic [GAIN_W-1:0]   r_g;
    logic [GAIN_W-1:0]   w_g_nxt;
    logic [GAIN_W-1:0]   w_g_up;
    logic [GAIN_W-1:0]   w_g_dn;
    logic [GAIN_W-1:0]   w_tgt;
    logic                w_tick;
    logic [W+GAIN_W-1:0] w_p;
    logic [W:0]          w_s_raw;
    logic [W-1:0]        w_s;
    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       w_acc_nxt;
    logic [W-1:0]        w_y;
    logic                r_clip;

    assign w_tick = (r_cnt == CNT_W'(DIV - 1));
    assign w_tgt  = mute ? '0 : vol;
    assign w_g_up = r_g + 1'b1;
    assign w_g_dn = r_g - 1'b1;

    // Gain multiply with unity at GAIN_UNITY; the extra top bit flags overload.
    assign w_p     = {{GAIN_W{1'b0}}, r_x} * {{W{1'b0}}, r_g};
    assign w_s_raw = w_p[W+GAIN_W-1:G_SH];
    assign w_s     = sat_u(w_s_raw);

    // Leaky integrator: bounded because the leak term matches the input at steady state.
    assign w_acc_nxt = r_acc + AW'(w_s) - (r_acc >> LPF_SH);
    assign w_y       = r_acc[AW-1:LPF_SH];

    assign muted = (r_g == '0);
    assign clip  = r_clip;

    // Capture a new sample on each strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_x <= '0;
        else if (snd_stb) r_x <= snd_in;
    end

    // Free-running tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end

    // Ramp state and current gain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ZERO;
            r_g     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
        end
    end

    // One gain step toward the target per tick; landing on the target settles.
    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        if (w_tick) begin
            case (r_state)
                S_ZERO: begin
                    if (w_tgt != '0) begin
                        w_g_nxt     = w_g_up;
                        w_state_nxt = S_UP;
                    end
                end
                default: begin
                    if (w_tgt > r_g) begin
                        w_g_nxt     = w_g_up;
                        w_state_nxt = (w_g_up == w_tgt) ? S_STEADY : S_UP;
                    end else if (w_tgt < r_g) begin
                        w_g_nxt     = w_g_dn;
                        w_state_nxt = (w_g_dn == '0)    ? S_ZERO :
                                      (w_g_dn == w_tgt) ? S_STEADY : S_DOWN;
                    end else begin
                        w_state_nxt = (r_g == '0) ? S_ZERO : S_STEADY;
                    end
                end
            endcase
        end
    end

    // Filter update and clip flag, both once per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_clip <= 1'b0;
        end else begin
            r_clip <= w_tick & w_s_raw[W];
            if (w_tick) r_acc <= w_acc_nxt;
        end
    end

    snd_sdm #(.W(W)) u_sdm (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (w_y),
        .dout  (dac_out)
    );

endmodule

// File: doc/snd_dac_out.md
Name: snd_dac_out

Overview:
- Downstream stage of every mapper's expansion-audio path: consumes the mapper's 16-bit unsigned `snd` word and drives the 1-bit cartridge audio DAC pin.
- Registers the sample, applies a 5-bit gain with pop-free ramping and mute, smooths with a first-order IIR low-pass, then converts to a bitstream with a first-order sigma-delta modulator.

Parameters:
- W, 16, sample width (matches mapper `snd` bus).
- LPF_SH, 4, IIR shift; filter coefficient is 2^-LPF_SH.
- DIV, 32, clk cycles per filter/ramp tick (2..256).

Ports:
- clk  in  1  system clock (same clock that drives mapper logic).
- rst_n  in  1  asynchronous active-low reset.
- snd_in  in  W  unsigned mapper audio sample.
- snd_stb  in  1  sample-valid strobe, one clk wide.
- vol  in  5  gain, unity = 16, range 0..31 (0..1.9375x).
- mute  in  1  level; forces ramp target to 0.
- dac_out  out  1  sigma-delta bitstream to audio pin.
- muted  out  1  high while effective gain is 0.
- clip  out  1  one-clk pulse when a scaled sample saturates.

Behaviour:
- Reset, asynchronous, active-low. Every register clears to 0:
  - x_reg, g_cur, acc and sd_acc clear; tick counter clears; dac_out = 0; clip = 0.
  - muted = 1, because g_cur = 0.
  - FSM = S_ZERO. After release the gain ramps up from 0 to avoid a pop.
- Capture:
  - x_reg <= snd_in on each clk with snd_stb = 1; held otherwise.
  - Latency: snd_in visible in x_reg 1 clk after the strobe.
- Tick counter:
  - Counts 0..DIV-1 and wraps.
  - tick = 1 for the single clk where count == DIV-1.
  - Free-running and independent of snd_stb.
- Gain target:
  - tgt = mute ? 0 : vol.
  - tgt is sampled each tick; changes between ticks act on the next tick.
- Ramp FSM. At most one step (+1 or -1) per tick, evaluated only on tick:
  - S_ZERO (g_cur == 0): tgt > 0 -> S_UP with g_cur = 1; otherwise stay.
  - S_UP:
    - g_cur < tgt -> g_cur + 1; when it reaches tgt -> S_STEADY.
    - tgt < g_cur (reversal mid-ramp) -> S_DOWN and step -1 on the same tick.
  - S_STEADY: tgt > g_cur -> S_UP; tgt < g_cur -> S_DOWN; both step on that tick.
  - S_DOWN:
    - g_cur - 1 each tick.
    - Reaches 0 -> S_ZERO.
    - Reaches tgt (tgt > 0) -> S_STEADY.
    - tgt > g_cur -> S_UP.
  - muted = (g_cur == 0), combinational from the register.
- Scaling, combinational every clk:
  - p = x_reg * g_cur (W+5 bits); s_raw = p >> 4 (W+1 bits).
  - s = s_raw[W] ? {W{1}} : s_raw[W-1:0].
  - clip pulses for 1 clk on each tick where s_raw[W] = 1.
- IIR low-pass:
  - acc is W+LPF_SH bits unsigned.
  - On tick: acc <= acc + s - (acc >> LPF_SH). This cannot underflow or overflow.
  - y = acc[W+LPF_SH-1:LPF_SH].
  - Steady state: y == s after enough ticks; within 1 LSB when s is constant.
- Sigma-delta, every clk regardless of tick:
  - {c, sd_acc[W-1:0]} <= sd_acc + y; dac_out <= c (registered).
  - Ones-density of dac_out = y / 2^W.
  - y = 0 -> dac_out constant 0.
- Simultaneous events:
  - snd_stb and tick in the same clk: the scaled value uses the old x_reg; the new sample is used from the next tick.
  - mute asserted and vol changed in the same window: mute wins.
- Reset mid-operation: async clear of all state per the reset bullet above, regardless of FSM state or pending tick.

Decomposition:
- Package snd_pkg holds:
  - the `snd_ramp_t` enum {S_ZERO, S_UP, S_STEADY, S_DOWN};
  - localparams GAIN_UNITY = 16, GAIN_W = 5, SND_W = 16.
- One sub-module, `snd_sdm`: a W-bit first-order sigma-delta with ports clk, rst_n, din[W-1:0], dout.
- Capture, ramp, scaling and IIR stay in the top.

Test Plan:
- Reset then vol = 16, mute = 0, constant snd_in = 0x8000 with strobe -> muted drops after 1st tick; g_cur reaches 16 after 16 ticks (16*DIV clks); y settles to 0x8000 ±1; dac_out density 0.5 ±2^-10 over 4096 clks.
- vol = 31, snd_in = 0xFFFF -> clip pulses once per tick; s = 0xFFFF; y saturates at 0xFFFF and never wraps.
- Steady at vol = 16, assert mute -> g_cur steps down once per tick, 0 after 16 ticks; muted = 1; dac_out constant 0 once y decays to 0.
- Mid-ramp reversal: vol 0->20, then at g_cur = 8 set mute -> next tick g_cur = 7, state S_DOWN; no tick ever changes g_cur by more than 1.
- snd_stb coincident with tick, snd_in 0x1000 -> 0x2000 -> that tick's scaled value uses 0x1000; the following tick uses 0x2000.
- Assert rst_n = 0 mid S_UP with y = 0x4000 -> immediately dac_out = 0, muted = 1, clip = 0, acc = 0; after release the ramp restarts from S_ZERO.
